c3lib_pulse_stretch: RTL
========================

C3LIB_PULSE_STRETCH -- requirements
Module: c3lib_pulse_stretch

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 4: width of stretch_len and the internal down-counter.
REQ-002 SHALL have parameter OVL_WIDTH, default 8: width of the merged-event counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  block enable; 0 forces idle.
REQ-006 SHALL have port retrig_en  input  1  1: a new rising edge during a stretch reloads the counter.
REQ-007 SHALL have port stretch_len  input  CNT_WIDTH  extra high cycles beyond 1; sampled only on load.
REQ-008 SHALL have port pulse_in  input  1  synchronous event input, any width.
REQ-009 SHALL have port ovl_clr  input  1  synchronous clear of ovl_cnt.
REQ-010 SHALL have port pulse_out  output  1  registered stretched pulse; feeds a downstream 2-input OR combiner.
REQ-011 SHALL have port busy  output  1  registered; 1 when the state is not IDLE.
REQ-012 SHALL have port ovl_cnt  output  OVL_WIDTH  saturating count of rising edges merged without reload.

Function
REQ-013 SHALL detect a rising edge as pulse_in=1 with prev=0, where prev is a register updated with pulse_in every cycle, independent of enable.
REQ-014 SHALL implement the states IDLE, STRETCH and HOLD; state, counter, pulse_out and busy are all registered.
REQ-015 IDLE: on a rising edge with enable=1, SHALL go to STRETCH and load cnt=stretch_len.
REQ-016 STRETCH: when cnt!=0, SHALL decrement cnt; when cnt==0, SHALL go to HOLD if pulse_in=1, otherwise to IDLE.
REQ-017 STRETCH with a rising edge and retrig_en=1 SHALL reload cnt=stretch_len; the reload takes priority over the decrement and exit of REQ-016.
REQ-018 STRETCH with a rising edge and retrig_en=0 SHALL leave cnt unchanged and increment ovl_cnt.
REQ-019 HOLD: SHALL stay while pulse_in=1 and go to IDLE when pulse_in=0; a rising edge in HOLD cannot occur.
REQ-020 pulse_out and busy SHALL equal (next_state != IDLE), registered.
- Latency: an edge sampled at cycle N gives pulse_out=1 at cycles N+1 .. N+1+stretch_len.
- Minimum width is stretch_len+1 cycles; stretch_len=0 gives a 1-cycle pulse.
REQ-021 With pulse_in still high at the end of the count, pulse_out SHALL stay high through HOLD and fall the cycle after pulse_in is sampled low.
REQ-022 enable=0 in any state SHALL force next_state=IDLE and clear cnt, so pulse_out=0 on the following cycle; ovl_cnt SHALL be unaffected.
REQ-023 Asserting enable while pulse_in is already high SHALL NOT trigger; a fresh rising edge is required.
REQ-024 ovl_cnt SHALL saturate at 2^OVL_WIDTH-1 and never wrap.
REQ-025 ovl_clr SHALL zero ovl_cnt next cycle; ovl_clr together with an increment event SHALL give 0 (clear wins).
REQ-026 The counter SHALL be exactly CNT_WIDTH bits; stretch_len=2^CNT_WIDTH-1 SHALL give 2^CNT_WIDTH high cycles with no overflow.
REQ-027 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-028 rst=1 SHALL set state=IDLE, cnt=0, pulse_out=0, busy=0, ovl_cnt=0 and prev=1 on the next clk edge.
REQ-029 rst SHALL override enable, ovl_clr and any in-progress stretch.
REQ-030 prev=1 at reset SHALL prevent an input held high through reset from triggering; a 0 then 1 sequence is required after reset.
REQ-031 Reset asserted mid-stretch SHALL drop pulse_out to 0 on the following cycle, with no residual pulse after release.

Verification
REQ-032 Scenario, basic stretch: CNT_WIDTH=4, stretch_len=3, 1-cycle pulse_in at cycle 10 -> pulse_out=1 for cycles 11-14 exactly, busy identical, ovl_cnt=0.
REQ-033 Scenario, retrigger: stretch_len=3, retrig_en=1, 1-cycle pulses at cycles 10 and 12 -> pulse_out=1 for cycles 11-16 contiguous; repeating with retrig_en=0 -> pulse_out=1 for cycles 11-14 and ovl_cnt=1.
REQ-034 Scenario, long input: stretch_len=1, pulse_in high for cycles 10-19 -> pulse_out=1 for cycles 11-20, passing through HOLD, with a single trigger.
REQ-035 Scenario, enable and reset mid-operation: stretch_len=15, edge at cycle 10, enable=0 at cycle 13 -> pulse_out=0 from cycle 14; same stimulus with rst=1 at cycle 13 -> all outputs 0 from cycle 14; pulse_in held high through reset release -> no trigger.
REQ-036 Scenario, saturation and clear: OVL_WIDTH=8, retrig_en=0, stretch_len=15, 300 merged edges -> ovl_cnt=255 and held; ovl_clr coincident with a merged edge -> ovl_cnt=0.
REQ-037 Scenario, boundaries: stretch_len=0 -> exactly 1-cycle pulse_out; stretch_len=15 -> exactly 16 cycles; back-to-back edges at cycles 10 and 12 with stretch_len=0 -> two separate 1-cycle pulses at cycles 11 and 13.

Source files
------------

// File: rtl/c3lib_pulse_stretch.sv
// ---------------------------------------------------------------------------
// c3lib_pulse_stretch
//
// Purpose:
//   Stretches any rising edge seen on pulse_in into an output pulse that is
//   at least stretch_len+1 cycles wide. If pulse_in is still high when the
//   count runs out, the output follows pulse_in (HOLD) until it drops.
//   Rising edges that arrive while a stretch is already running either
//   reload the counter (retrig_en=1) or are merged into the running pulse
//   and counted in a saturating overlap counter (retrig_en=0).
//
// Ports:
//   clk          single clock, all state changes on its rising edge
//   rst          synchronous, active-high reset
//   enable       block enable; 0 forces the FSM to IDLE and clears cnt
//   retrig_en    1: an edge during STRETCH reloads the counter
//   stretch_len  extra high cycles beyond the first; sampled only on load
//   pulse_in     synchronous event input, any width
//   ovl_clr      synchronous clear of ovl_cnt (wins over an increment)
//   pulse_out    registered stretched pulse
//   busy         registered; 1 whenever the FSM is not in IDLE
//   ovl_cnt      saturating count of edges merged without a reload
//
// Handshake: none. pulse_in is a level/event input with no back-pressure;
// every output is a flop, so there is no input-to-output combinational path.
// ---------------------------------------------------------------------------
module c3lib_pulse_stretch #(
    parameter int CNT_WIDTH = 4,
    parameter int OVL_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 retrig_en,
    input  logic [CNT_WIDTH-1:0] stretch_len,
    input  logic                 pulse_in,
    input  logic                 ovl_clr,
    output logic                 pulse_out,
    output logic                 busy,
    output logic [OVL_WIDTH-1:0] ovl_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STRETCH = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [OVL_WIDTH-1:0] OVL_ONE = {{(OVL_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 prev_q;
    logic                 rise;
    logic                 ovl_inc;
    logic                 ovl_sat;
    logic                 active_d;

    // ------------------------------------------------------------------
    // Edge detector. prev resets to 1 so that an input already high
    // across reset release is not mistaken for a new event; a 0 -> 1
    // sequence is needed. It tracks pulse_in regardless of enable, so
    // turning enable on while pulse_in is high does not trigger either.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= pulse_in;
        end
    end

    assign rise = pulse_in & ~prev_q;

    // ------------------------------------------------------------------
    // Next-state / counter logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovl_inc = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = STRETCH;
                        cnt_d   = stretch_len;
                    end
                end

                STRETCH: begin
                    if (rise && retrig_en) begin
                        // Reload beats both the decrement and the exit.
                        cnt_d = stretch_len;
                    end else begin
                        // A merged edge does not disturb the count: the
                        // running pulse simply absorbs it.
                        if (rise) begin
                            ovl_inc = 1'b1;
                        end
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNT_ONE;
                        end else if (pulse_in) begin
                            state_d = HOLD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end

                HOLD: begin
                    // pulse_in is high on entry and stays high here, so a
                    // rising edge cannot occur in this state.
                    if (!pulse_in) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from next_state and registered, so pulse_out
    // rises the cycle after the edge is sampled and has no comb path.
    assign active_d = (state_d != IDLE);

    // ------------------------------------------------------------------
    // State, counter and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pulse_out <= active_d;
            busy      <= active_d;
        end
    end

    // ------------------------------------------------------------------
    // Overlap counter: saturates at all-ones, clear wins over increment.
    // ------------------------------------------------------------------
    assign ovl_sat = (ovl_cnt == {OVL_WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            ovl_cnt <= '0;
        end else if (ovl_clr) begin
            ovl_cnt <= '0;
        end else if (ovl_inc && !ovl_sat) begin
            ovl_cnt <= ovl_cnt + OVL_ONE;
        end
    end

endmodule
